// File: rtl/uart_pkg.sv
// Shared types and constants for the user-project UART.
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_MIN_CLK_DIV = 4;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } uart_rx_state_e;

    // Clocks-per-bit below the supported minimum would leave no room for a mid-bit sample.
    function automatic logic [31:0] uart_clamp_div(input logic [31:0] clk_div,
                                                   input int          min_div);
        logic [31:0] min_v;
        min_v = 32'(min_div);
        return (clk_div < min_v) ? min_v : clk_div;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs; reset value is a parameter so
// idle-high lines come out of reset looking idle.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so both stages shift on the same edge.
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 receiver: synchronises rx, validates the start bit, samples each
// bit at its centre and hands bytes out on a valid/ready port with framing/overrun flags.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int MIN_CLK_DIV = UART_MIN_CLK_DIV
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [31:0]          clk_div,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    input  logic                 i_clr_ovr,
    output logic                 o_busy
);

    localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_rx_state_e       state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 ovr_q, ovr_d;
    logic                 prev_q, prev_d;
    logic [1:0]           settle_q, settle_d;

    logic                 rx_sync;
    logic [31:0]          div;
    logic [31:0]          half;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (rx),
        .q   (rx_sync)
    );

    assign div  = uart_clamp_div(clk_div, MIN_CLK_DIV);
    assign half = div >> 1;

    always_comb begin
        // NOTE: every signal gets its default first so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = '0;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~i_ready;
        frame_err_d = 1'b0;
        ovr_d       = ovr_q & ~i_clr_ovr;
        prev_d      = rx_sync;
        settle_d    = {settle_q[0], 1'b1};

        unique case (state_q)
            WAIT_IDLE: begin
                // The synchroniser's reset ones are stale until two real samples arrive.
                if (settle_q[1] && rx_sync) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                idx_d = '0;
                if (prev_q && !rx_sync) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == half - 32'd1) begin
                    state_d = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            DATA: begin
                if (cnt_q == div - 32'd1) begin
                    shift_d              = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rx_sync;
                    idx_d                = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            STOP: begin
                if (cnt_q == div - 32'd1) begin
                    if (rx_sync) begin
                        state_d = IDLE;
                        // A slot freed by this cycle's transfer may be refilled at once.
                        if (!valid_q || i_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_q       <= 1'b0;
            prev_q      <= 1'b1;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            ovr_q       <= ovr_d;
            prev_q      <= prev_d;
            settle_q    <= settle_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = state_q inside {START, DATA, STOP};

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed and randomised frames against uart_rx_sampler; expectations come from the
// frame timing rules and a byte/flag scoreboard kept in this bench.
module tb_uart_rx_sampler;

    logic        clk;
    logic        wb_rst_i;
    logic [31:0] clk_div;
    logic        rx;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_frame_err;
    logic        o_overrun;
    logic        i_clr_ovr;
    logic        o_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int   valid_log[$];
    int   xfer_log[$];
    int   ferr_log[$];
    int   busy_rise[$];
    int   busy_fall[$];
    logic busy_prev = 1'b0;

    uart_rx_sampler dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .clk_div     (clk_div),
        .rx          (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .i_clr_ovr   (i_clr_ovr),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle; cycle c is the interval after the c-th rising edge.
    always @(negedge clk) begin
        if (o_valid === 1'b1) valid_log.push_back(cyc);
        if (o_valid === 1'b1 && i_ready === 1'b1) xfer_log.push_back(int'(o_data));
        if (o_frame_err === 1'b1) ferr_log.push_back(cyc);
        if (o_busy === 1'b1 && !busy_prev) busy_rise.push_back(cyc);
        if (o_busy !== 1'b1 && busy_prev) busy_fall.push_back(cyc);
        busy_prev = (o_busy === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Whole 8N1 frame, each bit held for d cycles; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < d; j++) begin
                rx = fr[i];
                tick();
            end
        end
    endtask

    // Result cycle: edge seen 2 cycles after the pin falls, stop centre 9.5 bits later, +1 register.
    function automatic int done_cycle(input int f, input int e);
        return f + 2 + (e / 2) + 9 * e + 1;
    endfunction

    initial begin
        int         f, nv, nx, nf, nr, nq;
        int         e, d;
        logic [7:0] b;
        logic       sb;
        int         divs[6];
        divs = '{4, 5, 7, 11, 16, 2};

        rx        = 1'b1;
        i_ready   = 1'b0;
        i_clr_ovr = 1'b0;
        clk_div   = 32'd16;
        wb_rst_i  = 1'b1;
        repeat (3) tick();
        check("rst_data",      64'(o_data),      64'h0);
        check("rst_valid",     64'(o_valid),     64'h0);
        check("rst_busy",      64'(o_busy),      64'h0);
        check("rst_frame_err", 64'(o_frame_err), 64'h0);
        check("rst_overrun",   64'(o_overrun),   64'h0);
        wb_rst_i = 1'b0;
        repeat (8) tick();

        // Clean 0xA5 at 16 clocks per bit with the consumer always ready.
        i_ready = 1'b1;
        nv = valid_log.size(); nx = xfer_log.size();
        nr = busy_rise.size(); nf = busy_fall.size();
        f = cyc;
        send_frame(8'hA5, 1'b1, 16);
        repeat (20) tick();
        check("a5_valid_cycles", 64'(valid_log.size() - nv), 64'd1);
        check("a5_valid_at",  64'((valid_log.size() > nv) ? valid_log[nv] : -1), 64'(f + 155));
        check("a5_data",      64'((xfer_log.size() > nx) ? xfer_log[nx] : -1), 64'hA5);
        check("a5_busy_rise", 64'((busy_rise.size() > nr) ? busy_rise[nr] : -1), 64'(f + 3));
        check("a5_busy_fall", 64'((busy_fall.size() > nf) ? busy_fall[nf] : -1), 64'(f + 155));

        // Five-cycle low glitch must be rejected at the start-bit centre.
        nv = valid_log.size(); nq = ferr_log.size(); nf = busy_fall.size();
        f = cyc;
        rx = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        repeat (30) tick();
        check("glitch_no_valid", 64'(valid_log.size() - nv), 64'd0);
        check("glitch_no_ferr",  64'(ferr_log.size() - nq), 64'd0);
        check("glitch_busy_fall", 64'((busy_fall.size() > nf) ? busy_fall[nf] : -1), 64'(f + 11));
        check("glitch_idle", 64'(o_busy), 64'h0);
        nx = xfer_log.size();
        send_frame(8'h3C, 1'b1, 16);
        repeat (20) tick();
        check("post_glitch_data", 64'((xfer_log.size() > nx) ? xfer_log[nx] : -1), 64'h3C);

        // 0x55 with a low stop bit, line then held low like a break.
        nv = valid_log.size(); nq = ferr_log.size(); nr = busy_rise.size();
        f = cyc;
        send_frame(8'h55, 1'b0, 16);
        rx = 1'b0;
        repeat (60) tick();
        check("ferr_pulses",    64'(ferr_log.size() - nq), 64'd1);
        check("ferr_at",        64'((ferr_log.size() > nq) ? ferr_log[nq] : -1), 64'(f + 155));
        check("ferr_no_valid",  64'(valid_log.size() - nv), 64'd0);
        check("ferr_no_restart", 64'(busy_rise.size() - nr), 64'd1);
        check("ferr_hold_busy", 64'(o_busy), 64'h0);
        rx = 1'b1;
        repeat (10) tick();
        nx = xfer_log.size();
        send_frame(8'h81, 1'b1, 16);
        repeat (20) tick();
        check("post_ferr_data", 64'((xfer_log.size() > nx) ? xfer_log[nx] : -1), 64'h81);

        // Consumer stalled: second byte is dropped and overrun latches.
        i_ready = 1'b0;
        send_frame(8'h11, 1'b1, 16);
        repeat (20) tick();
        send_frame(8'h22, 1'b1, 16);
        repeat (20) tick();
        check("ovr_valid", 64'(o_valid),   64'h1);
        check("ovr_data",  64'(o_data),    64'h11);
        check("ovr_flag",  64'(o_overrun), 64'h1);
        i_clr_ovr = 1'b1;
        tick();
        i_clr_ovr = 1'b0;
        check("ovr_cleared", 64'(o_overrun), 64'h0);
        nx = xfer_log.size();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("ovr_xfer_old", 64'((xfer_log.size() > nx) ? xfer_log[nx] : -1), 64'h11);
        check("ovr_valid_drop", 64'(o_valid), 64'h0);

        // Transfer of a held byte in the exact cycle the next byte completes.
        send_frame(8'h33, 1'b1, 16);
        repeat (20) tick();
        nx = xfer_log.size();
        f = cyc;
        fork
            send_frame(8'h44, 1'b1, 16);
            begin
                repeat (154) tick();
                i_ready = 1'b1;
                tick();
                i_ready = 1'b0;
            end
        join
        repeat (5) tick();
        check("coinc_xfer_count", 64'(xfer_log.size() - nx), 64'd1);
        check("coinc_xfer_old", 64'((xfer_log.size() > nx) ? xfer_log[nx] : -1), 64'h33);
        check("coinc_valid",    64'(o_valid),   64'h1);
        check("coinc_data",     64'(o_data),    64'h44);
        check("coinc_no_ovr",   64'(o_overrun), 64'h0);
        nx = xfer_log.size();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("coinc_drain", 64'((xfer_log.size() > nx) ? xfer_log[nx] : -1), 64'h44);

        // Pending byte and overrun present, then reset during data bit 4 with rx low.
        send_frame(8'h5A, 1'b1, 16);
        repeat (20) tick();
        send_frame(8'h66, 1'b1, 16);
        repeat (20) tick();
        check("pre_rst_ovr", 64'(o_overrun), 64'h1);
        clk_div = 32'd2;
        repeat (4) tick();
        f = cyc;
        begin
            logic [9:0] fr;
            fr = {1'b1, 8'hC3, 1'b0};
            for (int i = 0; i < 22; i++) begin
                rx = fr[i / 4];
                tick();
            end
        end
        check("mid_frame_busy", 64'(o_busy), 64'h1);
        rx = 1'b0;
        wb_rst_i = 1'b1;
        repeat (2) tick();
        wb_rst_i = 1'b0;
        check("mrst_data",  64'(o_data),    64'h0);
        check("mrst_valid", 64'(o_valid),   64'h0);
        check("mrst_ovr",   64'(o_overrun), 64'h0);
        check("mrst_busy",  64'(o_busy),    64'h0);
        nr = busy_rise.size(); nv = valid_log.size();
        repeat (30) tick();
        check("low_after_rst_no_start", 64'(busy_rise.size() - nr), 64'd0);
        check("low_after_rst_no_valid", 64'(valid_log.size() - nv), 64'd0);
        rx = 1'b1;
        repeat (10) tick();
        i_ready = 1'b1;
        nv = valid_log.size(); nx = xfer_log.size();
        f = cyc;
        send_frame(8'hC3, 1'b1, 4);
        repeat (10) tick();
        check("div2_valid_at", 64'((valid_log.size() > nv) ? valid_log[nv] : -1),
              64'(done_cycle(f, 4)));
        check("div2_data", 64'((xfer_log.size() > nx) ? xfer_log[nx] : -1), 64'hC3);

        // Random bytes, rates and occasional bad stop bits against the scoreboard.
        for (int k = 0; k < 10; k++) begin
            d       = divs[$urandom_range(0, 5)];
            e       = (d < 4) ? 4 : d;
            b       = 8'($urandom);
            sb      = ($urandom_range(0, 3) != 0);
            clk_div = 32'(d);
            repeat (4) tick();
            nv = valid_log.size(); nx = xfer_log.size(); nq = ferr_log.size();
            f = cyc;
            send_frame(b, sb, e);
            rx = 1'b1;
            repeat (8) tick();
            if (sb) begin
                check("rnd_data", 64'((xfer_log.size() > nx) ? xfer_log[nx] : -1), 64'(b));
                check("rnd_valid_at", 64'((valid_log.size() > nv) ? valid_log[nv] : -1),
                      64'(done_cycle(f, e)));
                check("rnd_no_ferr", 64'(ferr_log.size() - nq), 64'd0);
            end else begin
                check("rnd_ferr_at", 64'((ferr_log.size() > nq) ? ferr_log[nq] : -1),
                      64'(done_cycle(f, e)));
                check("rnd_dropped", 64'(xfer_log.size() - nx), 64'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
